// File: rtl/waveform_fetch_ctrl_pkg.sv
// Shared types and constants for the waveform ROM fetch sequencer.
// Used by waveform_fetch_ctrl, its skid buffer and the bus interface.
package picomips_wave_pkg;

    localparam int WAVE_ADDR_W = 8;
    localparam int WAVE_DATA_W = 8;
    localparam int WAVE_LEN_W  = 9;

    typedef logic [WAVE_ADDR_W-1:0] wave_addr_t;
    typedef logic [WAVE_DATA_W-1:0] wave_data_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FIN
    } fetch_state_e;

    // A new read may go out only if it still fits in the 2-entry buffer
    // once the in-flight read and this cycle's pop are accounted for.
    function automatic logic can_issue(
        input logic [1:0] occ,
        input logic       infl,
        input logic       pop
    );
        return ({1'b0, occ} + {2'b00, infl}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/waveform_fetch_ctrl_if.sv
// Bus bundle for waveform_fetch_ctrl: control, ROM port and sample stream.
// master = environment (CPU, ROM, consumer); slave = the sequencer.
interface waveform_fetch_if
    import picomips_wave_pkg::*;
#(
    parameter int ADDR_W = WAVE_ADDR_W,
    parameter int DATA_W = WAVE_DATA_W,
    parameter int LEN_W  = WAVE_LEN_W
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              loop;
    logic              abort;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, len, loop, abort,
        output rom_data, out_ready,
        input  rom_addr, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, base_addr, len, loop, abort,
        input  rom_data, out_ready,
        output rom_addr, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/waveform_fetch_ctrl_skid.sv
// wave_skid_buf: 2-entry valid/ready FIFO with occupancy output and
// synchronous flush; head entry drives the output directly.
module wave_skid_buf
    import picomips_wave_pkg::*;
#(
    parameter int DATA_W = WAVE_DATA_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem0;
    logic [DATA_W-1:0] r_mem1;
    logic              r_rd;
    logic              r_wr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_wr) begin
                    r_mem1 <= i_push_data;
                end else begin
                    r_mem0 <= i_push_data;
                end
                r_wr <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_rd ? r_mem1 : r_mem0;
    assign o_count = r_count;

endmodule

// File: rtl/waveform_fetch_ctrl.sv
// waveform_fetch_ctrl: streams W[base..base+len-1] from a sync ROM onto a
// valid/ready port. Define WAVEFORM_FETCH_LOOP_EN for continuous playback.
module waveform_fetch_ctrl
    import picomips_wave_pkg::*;
#(
    parameter int ADDR_W = WAVE_ADDR_W,
    parameter int DATA_W = WAVE_DATA_W,
    parameter int LEN_W  = WAVE_LEN_W
)
(
    input  logic             clk,
    input  logic             rst,
    waveform_fetch_if.slave  bus
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remain;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;
`ifdef WAVEFORM_FETCH_LOOP_EN
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic              r_loop;
`endif

    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        w_count;
    logic              w_pop;
    logic              w_issue;
    logic              w_last;
    logic              w_empty_next;

    assign w_pop   = w_valid & bus.out_ready;
    assign w_issue = (r_state == FETCH) && can_issue(w_count, r_inflight, w_pop);
    assign w_last  = (r_remain == LEN_W'(1));

    // Leave DRAIN on the edge that empties the buffer, so done lands one
    // cycle after the final handshake.
    assign w_empty_next = !r_inflight &&
                          ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

    wave_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.abort),
        .i_push      (r_inflight),
        .i_push_data (bus.rom_data),
        .i_pop       (w_pop),
        .o_valid     (w_valid),
        .o_data      (w_data),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef WAVEFORM_FETCH_LOOP_EN
            r_base     <= '0;
            r_len      <= '0;
            r_loop     <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (bus.abort) begin
                r_state    <= IDLE;
                r_inflight <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_busy   <= 1'b1;
                            r_addr   <= bus.base_addr;
                            r_remain <= bus.len;
`ifdef WAVEFORM_FETCH_LOOP_EN
                            r_base   <= bus.base_addr;
                            r_len    <= bus.len;
                            r_loop   <= bus.loop;
`endif
                            r_state  <= (bus.len == '0) ? FIN : FETCH;
                        end
                    end
                    FETCH: begin
                        if (w_issue) begin
                            r_addr   <= r_addr + ADDR_W'(1);
                            r_remain <= r_remain - LEN_W'(1);
                            if (w_last) begin
`ifdef WAVEFORM_FETCH_LOOP_EN
                                if (r_loop) begin
                                    r_addr   <= r_base;
                                    r_remain <= r_len;
                                end else begin
                                    r_state  <= DRAIN;
                                end
`else
                                r_state <= DRAIN;
`endif
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_empty_next) begin
                            r_state <= FIN;
                        end
                    end
                    FIN: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr  = r_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_waveform_fetch_ctrl.sv
// Bench for waveform_fetch_ctrl with a behavioural sync ROM model and a
// data scoreboard on the sample port.
module tb_waveform_fetch_ctrl;
    import picomips_wave_pkg::*;

    logic clk = 1'b0;
    logic rst;

    waveform_fetch_if bus ();

    waveform_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] wv(input logic [7:0] a);
        return (a * 8'd13) ^ 8'hA5;
    endfunction

    always_ff @(posedge clk) bus.rom_data <= wv(bus.rom_addr);

    int          n_checks = 0;
    int          n_pass   = 0;
    int          hs_cnt   = 0;
    logic [7:0]  sb[$];

    // Scoreboard: a handshake seen here happens on the next rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            hs_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_extra: got %h, required no sample", bus.out_data);
            end else begin
                e = sb.pop_front();
                if (bus.out_data !== e)
                    $display("FAIL sb_data: got %h, required %h", bus.out_data, e);
                else
                    n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            #5;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        step();
        #5;
        n_checks++;
        if ({bus.rom_addr, bus.out_data} !== 16'h0)
            $display("FAIL rst_addr_data: got %h, required 0000", {bus.rom_addr, bus.out_data});
        else
            n_pass++;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.done} !== 3'b000)
            $display("FAIL rst_flags: got %b, required 000", {bus.out_valid, bus.busy, bus.done});
        else
            n_pass++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        step();
        bus.base_addr = 8'h00;
        bus.len = 9'd5;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back(wv(8'(i)));
        step();
        bus.start = 1'b0;
        #5;
        n_checks++;
        if (bus.rom_addr !== 8'h00 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL os_k: got addr=%h busy=%b v=%b, required 00 1 0",
                     bus.rom_addr, bus.busy, bus.out_valid);
        else
            n_pass++;
        step();
        #5;
        n_checks++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL os_k1_valid: got %b, required 0", bus.out_valid);
        else
            n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            #5;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.done !== 1'b0)
                $display("FAIL os_stream%0d: got v=%b d=%b, required 1 0",
                         i, bus.out_valid, bus.done);
            else
                n_pass++;
        end
        step();
        #5;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL os_after: got v=%b d=%b, required 0 0", bus.out_valid, bus.done);
        else
            n_pass++;
        step();
        #5;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL os_done: got d=%b busy=%b, required 1 0", bus.done, bus.busy);
        else
            n_pass++;
        step();
        #5;
        n_checks++;
        if (bus.done !== 1'b0)
            $display("FAIL os_done_pulse: got %b, required 0", bus.done);
        else
            n_pass++;
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL os_left: got %0d pending, required 0", sb.size());
        else
            n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] ea[4];
        bit seen;
        ea = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        step();
        bus.base_addr = 8'hFE;
        bus.len = 9'd4;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(wv(ea[i]));
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #5;
            n_checks++;
            if (bus.rom_addr !== ea[i])
                $display("FAIL wrap_addr%0d: got %h, required %h", i, bus.rom_addr, ea[i]);
            else
                n_pass++;
            step();
        end
        wait_done(30, seen);
        n_checks++;
        if (!seen || sb.size() != 0)
            $display("FAIL wrap_done: got done=%b pending=%0d, required 1 0", seen, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_backpressure();
        bit         prev_stall;
        bit         seen;
        logic [7:0] held;
        logic [7:0] iss;
        int         hs0;
        int         outst;
        int         max_out;
        prev_stall = 1'b0;
        seen = 1'b0;
        held = '0;
        max_out = 0;
        hs0 = hs_cnt;
        step();
        bus.base_addr = 8'h40;
        bus.len = 9'd8;
        bus.start = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(wv(8'h40 + 8'(i)));
        for (int c = 0; c < 80 && !seen; c++) begin
            step();
            bus.start = 1'b0;
            bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
            #5;
            iss = bus.rom_addr - 8'h40;
            outst = int'(iss) - (hs_cnt - hs0 - ((bus.out_valid && bus.out_ready) ? 1 : 0));
            if (outst > max_out) max_out = outst;
            if (prev_stall) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held)
                    $display("FAIL bp_stable: got v=%b %h, required 1 %h",
                             bus.out_valid, bus.out_data, held);
                else
                    n_pass++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        bus.out_ready = 1'b1;
        n_checks++;
        if (!seen || max_out > 2)
            $display("FAIL bp_credit: got done=%b max_outstanding=%0d, required 1 <=2",
                     seen, max_out);
        else
            n_pass++;
        n_checks++;
        if (hs_cnt - hs0 != 8 || sb.size() != 0)
            $display("FAIL bp_count: got %0d samples pending=%0d, required 8 0",
                     hs_cnt - hs0, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_abort();
        int hs0;
        bit seen;
        bit got3;
        got3 = 1'b0;
        step();
        bus.base_addr = 8'h20;
        bus.len = 9'd10;
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) sb.push_back(wv(8'h20 + 8'(i)));
        step();
        bus.start = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 40 && !got3; i++) begin
            #5;
            if (hs_cnt - hs0 == 3) got3 = 1'b1;
            else step();
        end
        step();
        bus.abort = 1'b1;
        bus.out_ready = 1'b0;
        sb.delete();
        step();
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        bus.base_addr = 8'h10;
        bus.len = 9'd2;
        bus.start = 1'b1;
        sb.push_back(wv(8'h10));
        sb.push_back(wv(8'h11));
        #5;
        n_checks++;
        if (!got3 || hs_cnt - hs0 != 3)
            $display("FAIL ab_hs: got %0d handshakes, required 3", hs_cnt - hs0);
        else
            n_pass++;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.done} !== 3'b000)
            $display("FAIL ab_state: got %b, required 000", {bus.out_valid, bus.busy, bus.done});
        else
            n_pass++;
        hs0 = hs_cnt;
        step();
        bus.start = 1'b0;
        wait_done(30, seen);
        n_checks++;
        if (!seen || hs_cnt - hs0 != 2 || sb.size() != 0)
            $display("FAIL ab_restart: got done=%b n=%0d pending=%0d, required 1 2 0",
                     seen, hs_cnt - hs0, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_edges();
        bit seen;
        bit any_v;
        // len == 0
        any_v = 1'b0;
        step();
        bus.base_addr = 8'h55;
        bus.len = 9'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        #5;
        any_v |= bus.out_valid;
        n_checks++;
        if (bus.done !== 1'b0)
            $display("FAIL z_early: got done=%b, required 0", bus.done);
        else
            n_pass++;
        step();
        #5;
        any_v |= bus.out_valid;
        n_checks++;
        if (bus.done !== 1'b1 || any_v)
            $display("FAIL z_done: got done=%b valid_seen=%b, required 1 0", bus.done, any_v);
        else
            n_pass++;
        // abort beats a simultaneous start
        step();
        bus.base_addr = 8'h70;
        bus.len = 9'd3;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #5;
        n_checks++;
        if (bus.busy !== 1'b0)
            $display("FAIL ab_wins: got busy=%b, required 0", bus.busy);
        else
            n_pass++;
        // start while busy is dropped
        step();
        bus.base_addr = 8'h30;
        bus.len = 9'd3;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(wv(8'h30 + 8'(i)));
        step();
        bus.start = 1'b0;
        step();
        bus.base_addr = 8'h80;
        bus.len = 9'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(30, seen);
        any_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            #5;
            any_v |= bus.out_valid | bus.busy;
        end
        n_checks++;
        if (!seen || any_v || sb.size() != 0)
            $display("FAIL busy_start: got done=%b extra=%b pending=%0d, required 1 0 0",
                     seen, any_v, sb.size());
        else
            n_pass++;
        // async reset mid-stream
        step();
        bus.base_addr = 8'h60;
        bus.len = 9'd20;
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) sb.push_back(wv(8'h60 + 8'(i)));
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if ({bus.rom_addr, bus.out_data} !== 16'h0 ||
            {bus.out_valid, bus.busy, bus.done} !== 3'b000)
            $display("FAIL async_rst: got %h %h %b, required 00 00 000",
                     bus.rom_addr, bus.out_data, {bus.out_valid, bus.busy, bus.done});
        else
            n_pass++;
        step();
        rst = 1'b0;
        any_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            #5;
            any_v |= bus.done | bus.out_valid;
        end
        n_checks++;
        if (any_v)
            $display("FAIL rst_quiet: got activity=%b, required 0", any_v);
        else
            n_pass++;
    endtask

    task automatic test_loop();
        bit seen;
`ifdef WAVEFORM_FETCH_LOOP_EN
        int hs0;
        bit got;
        got = 1'b0;
        seen = 1'b0;
        step();
        bus.base_addr = 8'h03;
        bus.len = 9'd2;
        bus.loop = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(wv(8'h03 + 8'(i % 2)));
        step();
        bus.start = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 60 && !got; i++) begin
            #5;
            seen |= bus.done;
            if (hs_cnt - hs0 == 8) got = 1'b1;
            else step();
        end
        step();
        bus.abort = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.abort = 1'b0;
        bus.loop = 1'b0;
        bus.out_ready = 1'b1;
        #5;
        seen |= bus.done;
        n_checks++;
        if (!got || seen || sb.size() != 0)
            $display("FAIL loop_stream: got 8seen=%b done=%b pending=%0d, required 1 0 0",
                     got, seen, sb.size());
        else
            n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL loop_abort: got v=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
        else
            n_pass++;
`else
        step();
        bus.base_addr = 8'h03;
        bus.len = 9'd2;
        bus.loop = 1'b1;
        bus.start = 1'b1;
        sb.push_back(wv(8'h03));
        sb.push_back(wv(8'h04));
        step();
        bus.start = 1'b0;
        wait_done(30, seen);
        bus.loop = 1'b0;
        n_checks++;
        if (!seen || sb.size() != 0)
            $display("FAIL loop_ignored: got done=%b pending=%0d, required 1 0", seen, sb.size());
        else
            n_pass++;
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.len = '0;
        bus.loop = 1'b0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_oneshot();
        test_wrap();
        test_backpressure();
        test_abort();
        test_edges();
        test_loop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
